jk_mode_register: RTL

- Parametrised multi-bit successor to the single-bit JK flip-flop: a WIDTH-bit register with per-bit J/K control, plus modulo up/down counting and parallel load.
- Used as the general state/count element in lab datapaths: counters, sequencers and bit-flag banks.
- State updates on the falling edge of Clk, matching the existing flip-flop family.

---
 rtl/jk_mode_register_if.sv | 31 +++
 rtl/jk_mode_register.sv | 102 ++++++++++
 2 files changed

// File: rtl/jk_mode_register_if.sv
`default_nettype none
// ============================================================================
//  Module   : jk_mode_register_if
//  Purpose  : Control/data bundle for jk_mode_register (operation select,
//             J/K/D operands, registered state and status flags).
//  Revision : 1.0  initial release
// ============================================================================
interface jk_mode_register_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, d,
        input  q, qbar, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qbar, tc, wrap
    );
endinterface
`default_nettype wire

// File: rtl/jk_mode_register.sv
`default_nettype none
// ============================================================================
//  Module   : jk_mode_register
//  Purpose  : WIDTH-bit register with per-bit JK control, modulo up/down
//             counting and parallel load. State changes on the falling edge
//             of Clk; asynchronous active-low reset.
//  Revision : 1.0  initial release
// ============================================================================
module jk_mode_register #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_VALUE = 0
) (
    input  wire logic          Clk,
    input  wire logic          nReset,
    jk_mode_register_if.slave  bus
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // One extra bit so MODULUS == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qbar_reg;
    logic             wrap_reg;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;
    logic             at_top;
    logic             at_zero;
    logic             out_of_range;

    assign at_top       = (q_reg >= TOP);
    assign at_zero      = (q_reg == '0);
    assign out_of_range = ({1'b0, q_reg} >= MOD_EXT);

    // Next-state selection for the four operations; En low holds Q.
    always_comb begin
        next_q    = q_reg;
        next_wrap = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_JK: begin
                    next_q = (bus.j & ~q_reg) | (~bus.k & q_reg);
                end
                MODE_UP: begin
                    // Values above the top (left by JK/load) also wrap to 0.
                    if (at_top) begin
                        next_q    = '0;
                        next_wrap = 1'b1;
                    end else begin
                        next_q = q_reg + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        next_q    = TOP;
                        next_wrap = 1'b1;
                    end else if (out_of_range) begin
                        // Range recovery lands on the top value without a wrap.
                        next_q = TOP;
                    end else begin
                        next_q = q_reg - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    next_q = bus.d;
                end
                default: begin
                    next_q = q_reg;
                end
            endcase
        end
    end

    // Q, Qbar and Wrap share one process so Qbar can never diverge from ~Q.
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            q_reg    <= RST_Q;
            qbar_reg <= ~RST_Q;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= next_q;
            qbar_reg <= ~next_q;
            wrap_reg <= next_wrap;
        end
    end

    assign bus.q    = q_reg;
    assign bus.qbar = qbar_reg;
    assign bus.wrap = wrap_reg;
    // Terminal count predicts the wrap that the next falling edge will take.
    assign bus.tc   = bus.en && (((bus.mode == MODE_UP) && at_top) ||
                                 ((bus.mode == MODE_DOWN) && at_zero));

endmodule
`default_nettype wire
